// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the PC / instruction-fetch stage.
//   - PCSEL encodings    : next-PC source chosen by the decoder
//   - BCOND encodings    : branch funct3 values
//   - fetch_state_e      : fetch FSM states
//   - NOP_INSTR          : instruction presented before the first fetch
//   - word_misaligned()  : true when a target is not on a 4-byte boundary
package riscv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

    localparam logic [1:0] PCSEL_SEQ    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JAL    = 2'b10;
    localparam logic [1:0] PCSEL_JALR   = 2'b11;

    localparam logic [2:0] BCOND_BEQ  = 3'b000;
    localparam logic [2:0] BCOND_BNE  = 3'b001;
    localparam logic [2:0] BCOND_BLT  = 3'b100;
    localparam logic [2:0] BCOND_BGE  = 3'b101;
    localparam logic [2:0] BCOND_BLTU = 3'b110;
    localparam logic [2:0] BCOND_BGEU = 3'b111;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_e;

    function automatic logic word_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
//   imem_req_valid  : fetch request valid          (fetch -> mem)
//   imem_addr       : fetch address                (fetch -> mem)
//   imem_req_ready  : memory accepts the request   (mem -> fetch)
//   imem_rsp_valid  : imem_rdata is valid          (mem -> fetch)
//   imem_rdata      : fetched instruction word     (mem -> fetch)
// master = fetch unit, slave = instruction memory.
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rdata
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator.
//   BCOND      : branch funct3
//   V,C,N,Z,L  : flags from the RS1 - RS2 compare (C = carry-out of
//                RS1 + ~RS2 + 1, L = signed less-than)
//   taken      : branch condition holds
module branch_cond_eval
    import riscv_fetch_pkg::*;
(
    input  logic [2:0] BCOND,
    input  logic       V,
    input  logic       C,
    input  logic       N,
    input  logic       Z,
    input  logic       L,
    output logic       taken
);
    // Signed compare is already resolved into L by the datapath, so V and N
    // are not needed here; they stay on the port for the pipelined core.
    logic unused_flags;
    assign unused_flags = V ^ N;

    always_comb begin
        taken = 1'b0;
        case (BCOND)
            BCOND_BEQ:  taken = Z;
            BCOND_BNE:  taken = ~Z;
            BCOND_BLT:  taken = L;
            BCOND_BGE:  taken = ~L;
            BCOND_BLTU: taken = ~C;     // no carry -> borrow -> RS1 < RS2 unsigned
            BCOND_BGEU: taken = C;
            default:    taken = 1'b0;   // 010 / 011 are not branch encodings
        endcase
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage of the single-cycle core.
// Fetches one instruction at a time over the imem bus, holds it for the
// datapath until acknowledged, then selects the next PC (sequential, branch,
// JAL, JALR). A misaligned target latches misalign and halts fetching until
// reset.
//   clk, reset      : clock, asynchronous active-high reset
//   imem            : instruction-memory bus (master side)
//   instr_valid     : instr/pc_out hold a live instruction
//   instr, pc_out   : current instruction and its PC
//   pc_plus4        : pc_out + 4 (link value)
//   instr_ack       : datapath commits instr this cycle
//   PCSEL, BCOND    : next-PC select and branch funct3
//   IMM, RS1_out    : immediate and rs1 value for target computation
//   V,C,N,Z,L       : compare flags from the datapath
//   misalign        : sticky, a taken target was not word-aligned
module pc_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_fetch_unit_if.master       imem,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [XLEN-1:0]       pc_out,
    output logic [XLEN-1:0]       pc_plus4,
    input  logic                  instr_ack,
    input  logic [1:0]            PCSEL,
    input  logic [2:0]            BCOND,
    input  logic [XLEN-1:0]       IMM,
    input  logic [XLEN-1:0]       RS1_out,
    input  logic                  V,
    input  logic                  C,
    input  logic                  N,
    input  logic                  Z,
    input  logic                  L,
    output logic                  misalign
);
    fetch_state_e    state_reg, state_next;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_out_reg;
    logic [31:0]     instr_reg;
    logic            misalign_reg;

    logic            branch_taken;
    logic [XLEN-1:0] next_pc;
    logic            target_misaligned;
    logic            capture;
    logic            hold_ack;
    logic            req_valid_c;
    logic            instr_valid_c;

    branch_cond_eval u_branch_cond_eval (
        .BCOND (BCOND),
        .V     (V),
        .C     (C),
        .N     (N),
        .Z     (Z),
        .L     (L),
        .taken (branch_taken)
    );

    // Next-PC selection; all sums wrap modulo 2^XLEN.
    always_comb begin
        next_pc = pc_reg + XLEN'(4);
        case (PCSEL)
            PCSEL_SEQ:    next_pc = pc_reg + XLEN'(4);
            PCSEL_BRANCH: next_pc = branch_taken ? (pc_reg + IMM) : (pc_reg + XLEN'(4));
            PCSEL_JAL:    next_pc = pc_reg + IMM;
            PCSEL_JALR:   next_pc = (RS1_out + IMM) & {{(XLEN-1){1'b1}}, 1'b0};
            default:      next_pc = pc_reg + XLEN'(4);
        endcase
    end

    assign target_misaligned = word_misaligned(next_pc[1:0]);
    assign capture           = (state_reg == ST_WAIT) && imem.imem_rsp_valid;
    assign hold_ack          = (state_reg == ST_HOLD) && instr_ack;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RST:  state_next = ST_REQ;
            ST_REQ:  if (imem.imem_req_ready) state_next = ST_WAIT;
            ST_WAIT: if (imem.imem_rsp_valid) state_next = ST_HOLD;
            ST_HOLD: if (instr_ack) state_next = target_misaligned ? ST_HALT : ST_REQ;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RST;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_valid_c   = 1'b0;
        instr_valid_c = 1'b0;
        case (state_reg)
            ST_REQ:  req_valid_c   = 1'b1;
            ST_HOLD: instr_valid_c = 1'b1;
            default: ;
        endcase
    end

    // PC, instruction register and sticky misalign flag. The PC is left
    // untouched on a misaligned target so imem_addr shows the faulting
    // instruction's address while halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            pc_out_reg   <= RESET_PC;
            instr_reg    <= NOP_INSTR;
            misalign_reg <= 1'b0;
        end else begin
            if (capture) begin
                instr_reg  <= imem.imem_rdata;
                pc_out_reg <= pc_reg;
            end
            if (hold_ack) begin
                if (target_misaligned) begin
                    misalign_reg <= 1'b1;
                end else begin
                    pc_reg <= next_pc;
                end
            end
        end
    end

    assign imem.imem_req_valid = req_valid_c;
    assign imem.imem_addr      = pc_reg;
    assign instr_valid         = instr_valid_c;
    assign instr               = instr_reg;
    assign pc_out              = pc_out_reg;
    assign pc_plus4            = pc_out_reg + XLEN'(4);
    assign misalign            = misalign_reg;
endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
    import riscv_fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        instr_ack;
    logic [1:0]  PCSEL;
    logic [2:0]  BCOND;
    logic [31:0] IMM, RS1_out;
    logic        V, C, N, Z, L;
    logic        instr_valid, misalign;
    logic [31:0] instr, pc_out, pc_plus4;

    // Second instance with RESET_PC at the top of the address space
    logic        instr_valid_b, misalign_b, instr_ack_b;
    logic [31:0] instr_b, pc_out_b, pc_plus4_b;

    pc_fetch_unit_if #(.XLEN(32)) ifa ();
    pc_fetch_unit_if #(.XLEN(32)) ifb ();

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .imem(ifa),
        .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .instr_ack(instr_ack), .PCSEL(PCSEL), .BCOND(BCOND), .IMM(IMM), .RS1_out(RS1_out),
        .V(V), .C(C), .N(N), .Z(Z), .L(L), .misalign(misalign)
    );

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .reset(reset), .imem(ifb),
        .instr_valid(instr_valid_b), .instr(instr_b), .pc_out(pc_out_b), .pc_plus4(pc_plus4_b),
        .instr_ack(instr_ack_b), .PCSEL(PCSEL_SEQ), .BCOND(3'b000), .IMM(32'h0), .RS1_out(32'h0),
        .V(1'b0), .C(1'b0), .N(1'b0), .Z(1'b0), .L(1'b0), .misalign(misalign_b)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_pc_out, m_instr;
    bit          m_hold, m_req, m_mis;
    bit          chk_en = 0;

    // Next PC straight from the ISA rules.
    function automatic logic [31:0] spec_next(input logic [31:0] pc, input logic [1:0] sel,
                                              input logic [2:0] bc, input logic [31:0] imm,
                                              input logic [31:0] rs1, input logic z, c, l);
        bit take;
        take = (bc == 3'b000 && z)  || (bc == 3'b001 && !z) ||
               (bc == 3'b100 && l)  || (bc == 3'b101 && !l) ||
               (bc == 3'b110 && !c) || (bc == 3'b111 && c);
        if (sel == 2'b11) return (rs1 + imm) & 32'hFFFF_FFFE;
        if (sel == 2'b10 || (sel == 2'b01 && take)) return pc + imm;
        return pc + 32'd4;
    endfunction

    // Compare process: every cycle, away from the active edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("imem_addr",      ifa.imem_addr,      m_pc);
            check("imem_req_valid", {31'b0, ifa.imem_req_valid}, {31'b0, m_req});
            check("instr_valid",    {31'b0, instr_valid},        {31'b0, m_hold});
            check("instr",          instr,              m_instr);
            check("pc_out",         pc_out,             m_pc_out);
            check("pc_plus4",       pc_plus4,           m_pc_out + 32'd4);
            check("misalign",       {31'b0, misalign},  {31'b0, m_mis});
        end
    end

    // ---------------- wrap-around instance environment ----------------
    logic [31:0] b_addr [3] = '{32'h0, 32'h0, 32'h0};
    int          b_cnt = 0;
    bit          b_armed = 0, b_pending = 0, b_p4_done = 0;
    logic [31:0] b_pc_out0 = 32'h0, b_p4_0 = 32'h1;

    assign instr_ack_b = instr_valid_b;
    initial begin
        ifb.imem_req_ready = 1'b1;
        ifb.imem_rsp_valid = 1'b0;
        ifb.imem_rdata     = 32'h0000_0033;
    end
    always @(negedge clk) begin
        ifb.imem_rsp_valid = b_pending;
        b_pending = ifb.imem_req_valid;
        if (b_armed && !reset) begin
            if (ifb.imem_req_valid && b_cnt < 3) begin
                b_addr[b_cnt] = ifb.imem_addr;
                b_cnt++;
            end
            if (instr_valid_b && !b_p4_done) begin
                b_pc_out0 = pc_out_b;
                b_p4_0    = pc_plus4_b;
                b_p4_done = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic model_reset();
        m_pc = 32'h0; m_pc_out = 32'h0; m_instr = NOP_INSTR;
        m_hold = 0; m_req = 0; m_mis = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifa.imem_req_ready = 1'b0;
        ifa.imem_rsp_valid = 1'b0;
        instr_ack = 1'b0;
        model_reset();
        #1;
        check("rst_req_valid",   {31'b0, ifa.imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid},        32'd0);
        check("rst_instr",       instr,                       32'h0000_0013);
        check("rst_pc_out",      pc_out,                      32'h0);
        check("rst_pc_plus4",    pc_plus4,                    32'h4);
        check("rst_misalign",    {31'b0, misalign},           32'd0);
        check("rst_addr",        ifa.imem_addr,               32'h0);
        chk_en = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        b_armed = 1;
        @(posedge clk);
        m_req = 1;                  // RST -> REQ on first edge after reset
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT in REQ; returns at a negedge in HOLD.
    // Stray responses and acks are driven where they must be ignored.
    task automatic fetch_instr(input int stall, input int rsp_lat, input logic [31:0] word);
        for (int i = 0; i < stall; i++) begin
            ifa.imem_req_ready = 1'b0;
            ifa.imem_rsp_valid = 1'b1;
            ifa.imem_rdata     = 32'hDEAD_BEEF;
            instr_ack          = 1'b1;
            @(negedge clk);
        end
        ifa.imem_req_ready = 1'b1;
        ifa.imem_rsp_valid = 1'b0;
        instr_ack          = 1'b0;
        @(posedge clk);
        m_req = 0;
        @(negedge clk);
        ifa.imem_req_ready = 1'b0;
        for (int i = 1; i < rsp_lat; i++) begin
            ifa.imem_rsp_valid = 1'b0;
            instr_ack          = 1'b1;
            @(negedge clk);
        end
        instr_ack          = 1'b0;
        ifa.imem_rsp_valid = 1'b1;
        ifa.imem_rdata     = word;
        @(posedge clk);
        m_instr = word; m_pc_out = m_pc; m_hold = 1;
        @(negedge clk);
        ifa.imem_rsp_valid = 1'b0;
    endtask

    // Called at a negedge in HOLD; acks after hold_wait idle cycles.
    task automatic ack_cmd(input string name, input logic [1:0] sel, input logic [2:0] bc,
                           input logic [31:0] imm, input logic [31:0] rs1,
                           input logic z, input logic c, input logic l, input int hold_wait,
                           input logic exp_mis, input logic [31:0] exp_addr);
        logic [31:0] nxt;
        for (int i = 0; i < hold_wait; i++) begin
            instr_ack = 1'b0;
            ifa.imem_rsp_valid = 1'b1;
            ifa.imem_rdata     = 32'hBAD0_0BAD;
            @(negedge clk);
        end
        ifa.imem_rsp_valid = 1'b1;
        ifa.imem_rdata     = 32'hBAD0_0BAD;
        instr_ack = 1'b1;
        PCSEL = sel; BCOND = bc; IMM = imm; RS1_out = rs1;
        Z = z; C = c; L = l; V = 1'($urandom); N = 1'($urandom);
        @(posedge clk);
        nxt = spec_next(m_pc, sel, bc, imm, rs1, z, c, l);
        m_hold = 0;
        if (nxt[1:0] != 2'b00) begin
            m_mis = 1;
        end else begin
            m_pc  = nxt;
            m_req = 1;
        end
        #1;
        if (exp_mis) check({name, "_misalign"}, {31'b0, misalign}, 32'd1);
        else         check({name, "_addr"},     ifa.imem_addr,     exp_addr);
        @(negedge clk);
        instr_ack = 1'b0;
        ifa.imem_rsp_valid = 1'b0;
        PCSEL = 2'($urandom); BCOND = 3'($urandom); IMM = $urandom; RS1_out = $urandom;
        Z = 1'($urandom); C = 1'($urandom); L = 1'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        instr_ack = 1'b0; PCSEL = 2'b00; BCOND = 3'b000; IMM = 32'h0; RS1_out = 32'h0;
        V = 0; C = 0; N = 0; Z = 0; L = 0;
        ifa.imem_req_ready = 1'b0; ifa.imem_rsp_valid = 1'b0; ifa.imem_rdata = 32'h0;
        model_reset();

        do_reset();
        fetch_instr(0, 1, 32'h0010_0093); ack_cmd("seq0",  PCSEL_SEQ,    3'b000, 32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h4);
        fetch_instr(0, 1, 32'h0020_0113); ack_cmd("seq1",  PCSEL_SEQ,    3'b000, 32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h8);
        fetch_instr(0, 1, 32'hFE00_0CE3); ack_cmd("beq_t", PCSEL_BRANCH, BCOND_BEQ,  32'hFFFF_FFF8, 32'h0, 1, 0, 0, 0, 0, 32'h0);
        fetch_instr(0, 1, 32'h0010_0093); ack_cmd("seq2",  PCSEL_SEQ,    3'b000, 32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h4);
        fetch_instr(0, 1, 32'h0020_0113); ack_cmd("seq3",  PCSEL_SEQ,    3'b000, 32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h8);
        fetch_instr(0, 1, 32'hFE00_0CE3); ack_cmd("beq_n", PCSEL_BRANCH, BCOND_BEQ,  32'hFFFF_FFF8, 32'h0, 0, 1, 1, 0, 0, 32'hC);
        fetch_instr(0, 1, 32'hFE20_EEE3); ack_cmd("bltu",  PCSEL_BRANCH, BCOND_BLTU, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0, 32'h8);
        fetch_instr(0, 1, 32'h0620_F263); ack_cmd("bgeu",  PCSEL_BRANCH, BCOND_BGEU, 32'd100,       32'h0, 0, 0, 0, 0, 0, 32'hC);
        fetch_instr(0, 1, 32'h0200_00EF); ack_cmd("jal",   PCSEL_JAL,    3'b000,     32'h20,        32'h0, 0, 0, 0, 0, 0, 32'h2C);
        fetch_instr(0, 1, 32'h0020_1463); ack_cmd("bne",   PCSEL_BRANCH, BCOND_BNE,  32'h8,         32'h0, 0, 0, 0, 0, 0, 32'h34);
        fetch_instr(0, 1, 32'hFE20_46E3); ack_cmd("blt",   PCSEL_BRANCH, BCOND_BLT,  32'hFFFF_FFEC, 32'h0, 0, 1, 1, 0, 0, 32'h20);
        fetch_instr(0, 1, 32'h0420_5063); ack_cmd("bge",   PCSEL_BRANCH, BCOND_BGE,  32'h40,        32'h0, 1, 1, 1, 0, 0, 32'h24);
        fetch_instr(0, 1, 32'h0420_2063); ack_cmd("bc010", PCSEL_BRANCH, 3'b010,     32'h40,        32'h0, 1, 1, 1, 1, 0, 32'h28);
        // Memory stalls: ready low 4 cycles, response 5 cycles after accept
        fetch_instr(4, 5, 32'h0040_8067); ack_cmd("jalr",  PCSEL_JALR,   3'b000,     32'h4,  32'h101, 0, 0, 0, 2, 0, 32'h104);
        fetch_instr(0, 1, 32'h0000_8067); ack_cmd("jalr_mis", PCSEL_JALR, 3'b000,    32'h0,  32'h102, 0, 0, 0, 0, 1, 32'h0);
        // Halted: responses and acks must not revive the unit
        for (int i = 0; i < 6; i++) begin
            ifa.imem_rsp_valid = 1'b1; ifa.imem_req_ready = 1'b1; instr_ack = 1'b1;
            @(negedge clk);
        end
        ifa.imem_rsp_valid = 1'b0; ifa.imem_req_ready = 1'b0; instr_ack = 1'b0;
        check("halt_pc_held", ifa.imem_addr, 32'h104);

        // Reset during WAIT; the late response must be discarded
        do_reset();
        ifa.imem_req_ready = 1'b1;
        @(posedge clk);
        m_req = 0;
        @(negedge clk);
        ifa.imem_req_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        ifa.imem_rsp_valid = 1'b1;
        ifa.imem_rdata     = 32'h0BAD_F00D;
        @(posedge clk);
        m_req = 1;
        @(negedge clk);
        #1 check("late_rsp_ignored", instr, 32'h0000_0013);
        fetch_instr(2, 1, 32'h0010_0093); ack_cmd("restart", PCSEL_SEQ, 3'b000, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h4);
        repeat (2) @(negedge clk);

        // Wrap-around instance
        check("wrap_fetch_count", b_cnt,     32'd3);
        check("wrap_addr0",       b_addr[0], 32'hFFFF_FFFC);
        check("wrap_addr1",       b_addr[1], 32'h0000_0000);
        check("wrap_addr2",       b_addr[2], 32'h0000_0004);
        check("wrap_pc_out",      b_pc_out0, 32'hFFFF_FFFC);
        check("wrap_pc_plus4",    b_p4_0,    32'h0000_0000);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the single-cycle RISC-V core, upstream of the datapath/data-memory block (DP_DM). It holds the PC, fetches instructions over a valid/ready instruction-memory interface, and presents one instruction at a time to the decoder/datapath. After each instruction commits, it selects the next PC from sequential, branch, JAL or JALR targets, using the DP_DM flags and `RS1_out`.

## Interface
- `XLEN`, 32: PC and instruction width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts the request this cycle.
- `imem_addr`  out  XLEN: fetch address; always equals the current PC.
- `imem_rsp_valid`  in  1: `imem_rdata` is valid.
- `imem_rdata`  in  32: fetched instruction word.
- `instr_valid`  out  1: `instr`/`pc_out` hold a live instruction.
- `instr`  out  32: current instruction.
- `pc_out`  out  XLEN: PC of `instr`; drives DP_DM `PC`.
- `pc_plus4`  out  XLEN: `pc_out + 4`, used as the link value.
- `instr_ack`  in  1: the datapath commits `instr` this cycle.
- `PCSEL`  in  2: next-PC select from the decoder. 00 = sequential, 01 = conditional branch, 10 = JAL, 11 = JALR.
- `BCOND`  in  3: branch funct3.
- `IMM`  in  XLEN: sign-extended immediate from the decoder.
- `RS1_out`  in  XLEN: rs1 value from DP_DM.
- `V`, `C`, `N`, `Z`, `L`  in  1 each: DP_DM flags from the `RS1 - RS2` compare.
- `misalign`  out  1: sticky flag; a taken target was not word-aligned.

## Operation
- **States:** RST, REQ, WAIT, HOLD, HALT.
- **RST:** entered on reset. Moves to REQ on the first clock edge after reset deasserts.
- **REQ:**
  - `imem_req_valid` = 1.
  - When `imem_req_ready` = 1, go to WAIT.
  - The address stays stable until accepted.
- **WAIT:**
  - On `imem_rsp_valid`, capture `imem_rdata` into `instr` and go to HOLD.
  - `imem_rsp_valid` is ignored in every state except WAIT.
- **HOLD:**
  - `instr_valid` = 1 and stays asserted until `instr_ack`.
  - On `instr_ack`: compute the next PC, load it into PC, go to REQ.
  - `PCSEL`, `BCOND`, `IMM`, `RS1_out` and the flags are sampled only in the ack cycle.
- **Next PC:**
  - Sequential, or branch not taken: PC + 4.
  - Branch taken or JAL: PC + IMM.
  - JALR: (RS1_out + IMM) with bit 0 cleared.
  - All sums are modulo 2^XLEN, so 32'hFFFF_FFFC + 4 = 0.
- **Branch conditions** (C = carry-out of RS1 + ~RS2 + 1; L = signed less-than):
  - 000 BEQ: Z
  - 001 BNE: !Z
  - 100 BLT: L
  - 101 BGE: !L
  - 110 BLTU: !C
  - 111 BGEU: C
  - 010 / 011: never taken.
- **Misaligned target:** if the selected next PC has bits [1:0] ≠ 0:
  - set `misalign`, do not load PC, go to HALT.
- **HALT:** no requests, `instr_valid` = 0. Only reset exits HALT.

## Timing
- **Reset values:**
  - PC = `RESET_PC`, `pc_out` = `RESET_PC`, `pc_plus4` = `RESET_PC` + 4.
  - `instr` = 32'h0000_0013 (NOP).
  - `instr_valid` = 0, `imem_req_valid` = 0, `misalign` = 0.
  - State = RST.
- **Best-case per instruction:**
  - Request accepted in cycle t.
  - Response in t+1.
  - `instr_valid` high in t+2; ack in t+2.
  - Next request in t+3.
  - CPI = 3.
- `instr_valid` drops in the cycle after the ack.
- `instr` and `pc_out` are registered and change only on capture or reset.
- Ack outside HOLD is ignored.
- Reset asserted mid-fetch or mid-HOLD: immediately returns to reset values. An in-flight response is discarded, because the state is RST, not WAIT.
- `imem_req_valid` never de-asserts in REQ before `imem_req_ready`.

## Structure
- **Package `riscv_fetch_pkg`:**
  - PCSEL encodings
  - BCOND encodings
  - fetch state enum
  - `NOP_INSTR` constant (32'h0000_0013)
- **Sub-module `branch_cond_eval`:** combinational; inputs `BCOND`, V, C, N, Z, L; output `taken`. It is reused later by the pipelined core.
- **Top level:** FSM, PC register, instruction register and next-PC adder.

## Test plan
- **Reset and sequential fetch:**
  - Stimulus: reset pulse; memory always ready, 1-cycle response; ack each instruction with `PCSEL` = 00.
  - Required response: `imem_addr` sequence 0, 4, 8; `instr_valid` every 3rd cycle.
- **Taken BEQ:**
  - Stimulus: PC = 8, `PCSEL` = 01, `BCOND` = 000, Z = 1, `IMM` = −8.
  - Required response: next `imem_addr` = 0.
- **Not-taken BEQ:** same stimulus with Z = 0 → next `imem_addr` = 12.
- **BLTU / BGEU:** C = 0 with `BCOND` = 110 → taken; C = 0 with `BCOND` = 111 → PC + 4.
- **JALR:**
  - Stimulus: `RS1_out` = 32'h101, `IMM` = 4, `PCSEL` = 11.
  - Required response: target 32'h104.
- **Misaligned JALR:**
  - Stimulus: `RS1_out` = 32'h102, `IMM` = 0.
  - Required response: `misalign` = 1; no further `imem_req_valid`.
- **Memory stalls and mid-wait reset:**
  - Stimulus: `imem_req_ready` low for 4 cycles, response after 5 cycles.
  - Required response: address stable throughout, single capture.
  - Then assert reset during WAIT: the late `imem_rsp_valid` is ignored and the fetch restarts at `RESET_PC`.
- **Wrap-around:** `RESET_PC` = 32'hFFFF_FFFC with a sequential ack → next `imem_addr` = 0.
